// File: rtl/instr_fetch.sv
// Instruction fetch stage: loadable program memory plus pc sequencer feeding the CPU one word per cycle.
// Latency: instruction valid one edge after start/advance; stall holds the word and pc in place.
module instr_fetch #(
   parameter int             IW        = 21,
   parameter int             AW        = 5,
   parameter int             DEPTH     = 32,
   parameter int             CW        = 16,
   parameter logic [IW-1:0]  NOP_INSTR = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          stop,
   input  logic          stall,
   input  logic          loop_en,
   input  logic [AW-1:0] last_addr,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [IW-1:0] prog_data,
   output logic [IW-1:0] instruction,
   output logic          instr_valid,
   output logic [AW-1:0] pc,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] fetch_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   logic [IW-1:0] mem_q [DEPTH];

   state_t        state_q, state_d;
   logic [IW-1:0] instr_q, instr_d;
   logic          vld_q,   vld_d;
   logic [AW-1:0] pc_q,    pc_d;
   logic [AW-1:0] last_q,  last_d;
   logic [CW-1:0] cnt_q,   cnt_d;

   logic [AW-1:0] pc_inc;
   logic [CW-1:0] cnt_inc;
   logic          mem_we;

   assign pc_inc  = pc_q + 1'b1;
   assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
   assign mem_we  = prog_we && !rst && (state_q != S_RUN);

   // Program memory survives rst; writes are locked out while running.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[prog_addr] <= prog_data;
      end
   end

   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      vld_d   = vld_q;
      pc_d    = pc_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               instr_d = mem_q[0];
               vld_d   = 1'b1;
               pc_d    = '0;
               cnt_d   = {{(CW-1){1'b0}}, 1'b1};
               last_d  = last_addr;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (stop) begin
               instr_d = NOP_INSTR;
               vld_d   = 1'b0;
               state_d = S_DONE;
            end else if (!stall) begin
               if (pc_q != last_q) begin
                  pc_d    = pc_inc;
                  instr_d = mem_q[pc_inc];
                  cnt_d   = cnt_inc;
               end else if (loop_en) begin
                  pc_d    = '0;
                  instr_d = mem_q[0];
                  cnt_d   = cnt_inc;
               end else begin
                  // End of program: pc parks on last_addr for inspection.
                  instr_d = NOP_INSTR;
                  vld_d   = 1'b0;
                  state_d = S_DONE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            instr_d = NOP_INSTR;
            vld_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         instr_q <= NOP_INSTR;
         vld_q   <= 1'b0;
         pc_q    <= '0;
         last_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         vld_q   <= vld_d;
         pc_q    <= pc_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   assign instruction = instr_q;
   assign instr_valid = vld_q;
   assign pc          = pc_q;
   assign fetch_count = cnt_q;
   assign busy        = (state_q == S_RUN);
   assign done        = (state_q == S_DONE);

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage sitting directly upstream of the CPU core.
- Holds a loadable program memory and a program counter, and presents one 21-bit instruction per cycle on the CPU's instruction input.
- Run/stop/stall control and optional looping; the top level gates the CPU's register-file load with instr_valid.

Parameters:
IW, 21, instruction width (z | op | im | src1 | src2 | dst).
AW, 5, program address width.
DEPTH, 32, program memory words (must equal 2**AW).
CW, 16, fetch counter width.
NOP_INSTR, 21'h0, value driven on instruction whenever instr_valid=0.

Ports:
clk  in  1  system clock, all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  begin execution at address 0 (IDLE/DONE only).
stop  in  1  abort execution (RUN only).
stall  in  1  hold current instruction and pc (RUN only).
loop_en  in  1  wrap to address 0 after last_addr instead of finishing.
last_addr  in  AW  address of final program word; sampled at start.
prog_we  in  1  program memory write enable.
prog_addr  in  AW  program memory write address.
prog_data  in  IW  program memory write data.
instruction  out  IW  registered instruction to CPU.
instr_valid  out  1  instruction is a real fetched word.
pc  out  AW  address of word currently on instruction.
busy  out  1  state==RUN.
done  out  1  state==DONE.
fetch_count  out  CW  number of valid instructions issued since last start, saturating.

Behaviour:
- States: IDLE, RUN, DONE. State is fully registered; every output is a register or decodes state.
- Reset (rst=1 at edge), highest priority:
  - state=IDLE, instruction=NOP_INSTR, instr_valid=0, pc=0, fetch_count=0, busy=0, done=0.
  - Stored last_addr copy=0.
  - Program memory contents are NOT cleared by rst.
- Reset mid-RUN: IDLE on the next edge, with no further valid instructions.
- Program writes:
  - Accepted when prog_we=1 and state is IDLE or DONE; mem[prog_addr]<=prog_data.
  - Silently ignored in RUN.
- IDLE or DONE, start=1:
  - instruction<=mem[0], instr_valid<=1, pc<=0, fetch_count<=1.
  - Latch last_addr; state<=RUN.
  - Read-before-write: a prog_we to address 0 in the same cycle is stored, but the instruction issued is the old mem[0].
  - stop and stall are ignored outside RUN.
- RUN, priority stop > stall > advance:
  - stop=1: instruction<=NOP_INSTR, instr_valid<=0, state<=DONE; pc holds.
  - stall=1: instruction, instr_valid, pc and fetch_count hold. The same word is presented again and must not be counted twice.
  - Advance with pc!=latched last_addr: pc<=pc+1, instruction<=mem[pc+1], fetch_count+1.
  - Advance with pc==latched last_addr, loop_en=1: pc<=0, instruction<=mem[0], fetch_count+1, stay RUN.
  - Advance with pc==latched last_addr, loop_en=0: instruction<=NOP_INSTR, instr_valid<=0, state<=DONE; pc holds at last_addr.
  - start=1 in RUN is ignored.
- Latency: an instruction appears one edge after start or advance, and exactly one word is issued per non-stalled RUN cycle.
- last_addr=0: a single instruction is issued, then DONE (or mem[0] is repeated every cycle if loop_en=1).
- fetch_count saturates at 2**CW-1 and does not wrap. It holds its value in DONE and IDLE until the next start or rst.
- loop_en is sampled every cycle, so changing it mid-run affects the next wrap decision.
- pc arithmetic is AW bits; pc+1 never exceeds last_addr, so there is no implicit wrap other than the loop_en wrap.

Test Plan:
- Load mem[0..3]=21'h00001,21'h00002,21'h00003,21'h00004; last_addr=3, loop_en=0; pulse start -> next 4 cycles instruction=1,2,3,4 with instr_valid=1, pc=0..3; then instr_valid=0, instruction=0, done=1, fetch_count=4.
- Same program; stall high for 2 cycles while pc=1 -> instruction=2 held 3 cycles total, fetch_count ends at 4; completion at cycle 7 after start.
- loop_en=1, last_addr=1 -> pc sequence 0,1,0,1,0...; busy stays 1; stop pulse -> next edge instr_valid=0, done=1, pc unchanged.
- During RUN, prog_we=1 with prog_addr=2, prog_data=21'h1ABCD -> mem[2] unchanged, checked on a rerun; write in DONE then start -> new word issued at pc=2.
- rst asserted while pc=2 in RUN -> next edge state IDLE, instr_valid=0, pc=0, fetch_count=0; memory is retained and a following start reissues the original words.
- Edge cases:
  - last_addr=0, loop_en=0: exactly one valid cycle with mem[0], then done=1.
  - start with simultaneous prog_we to addr 0: old mem[0] is issued, and the new value is seen on the next start.
